mem_port_arbiter: RTL and testbench

Single-port memory scheduler for the five-stage pipelined core. It shares one fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store), serialising their accesses and giving data accesses priority. It freezes the whole pipeline via `stall_pipe` until every access requested in the current pipeline step has completed. It sits between the pipeline registers and the unified memory, in place of separate instruction and data memories.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Single-port scheduler that shares one fixed-latency unified memory between
// instruction fetch (IF) and data load/store (MEM). Data accesses win when both
// are pending. The pipeline is frozen via stall_pipe until every access
// requested in the current pipeline step has completed. All state updates on
// the falling edge of CLK, matching the pipeline registers.
//
// Parameters:
//   WAIT_CYCLES  extra memory latency (0..7); one access takes WAIT_CYCLES+1 cycles
//
// Ports:
//   CLK, Reset_L          clock (falling-edge active), async active-low reset
//   if_req, if_addr       fetch request and byte address
//   if_rdata, if_ready    fetched word (held), fetch done for this step
//   d_rd, d_wr            load / store request (both high = store)
//   d_addr, d_wdata       data byte address, store data
//   d_rdata, d_ready      load data (held), data access done for this step
//   stall_pipe            freeze PC, pipeline registers and hazard state
//   mem_en, mem_we        memory access active / write
//   mem_addr, mem_wdata   latched command towards memory
//   mem_rdata             memory read data, valid in the last access cycle

module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        stall_pipe,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusyD, StBusyI} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        if_done_q;
  logic        d_done_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  logic d_pend;
  logic i_pend;
  logic busy;
  logic last;
  logic grant_ok;
  logic grant_d;
  logic grant_i;

  always_comb begin
    d_pend   = (d_rd | d_wr) & ~d_done_q;
    i_pend   = if_req & ~if_done_q;
    busy     = (state_q != StIdle);
    last     = busy && (cnt_q == 3'd0);
    grant_ok = !busy || last;
    // At a completion the request just served must not be granted again, so
    // the grant looks at the done flags as they will be after this edge.
    grant_d  = (d_rd | d_wr) & ~(d_done_q | (last && (state_q == StBusyD)));
    grant_i  = if_req & ~(if_done_q | (last && (state_q == StBusyI)));
  end

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      // Completion: capture read data and mark the requester served.
      if (last) begin
        if (state_q == StBusyD) begin
          d_done_q <= 1'b1;
          if (!we_q) begin
            d_rdata_q <= mem_rdata;
          end
        end else begin
          if_done_q  <= 1'b1;
          if_rdata_q <= mem_rdata;
        end
      end else if (!stall_pipe) begin
        // Pipeline advances at this edge: a new step begins.
        if_done_q <= 1'b0;
        d_done_q  <= 1'b0;
      end

      if (grant_ok) begin
        if (grant_d) begin
          state_q <= StBusyD;
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
          we_q    <= d_wr;
          cnt_q   <= 3'(WAIT_CYCLES);
        end else if (grant_i) begin
          state_q <= StBusyI;
          addr_q  <= if_addr;
          we_q    <= 1'b0;
          cnt_q   <= 3'(WAIT_CYCLES);
        end else begin
          state_q <= StIdle;
        end
      end else begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  assign if_rdata   = if_rdata_q;
  assign if_ready   = if_done_q;
  assign d_rdata    = d_rdata_q;
  assign d_ready    = d_done_q;
  assign stall_pipe = i_pend | d_pend | busy;
  assign mem_en     = busy;
  assign mem_we     = busy & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  int          sel = 0;

  // One instance per latency; only the selected one sees requests.
  logic [31:0] if_rdata_a  [4];
  logic [31:0] d_rdata_a   [4];
  logic [31:0] mem_addr_a  [4];
  logic [31:0] mem_wdata_a [4];
  logic [31:0] mem_rdata_a [4];
  logic [3:0]  if_ready_a;
  logic [3:0]  d_ready_a;
  logic [3:0]  stall_a;
  logic [3:0]  mem_en_a;
  logic [3:0]  mem_we_a;

  // Read-only memory model: a few fixed words, otherwise derived from address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'h2002000A;
    if (a == 32'h10) return 32'h5;
    if (a == 32'h44) return 32'h8C030000;
    return {a[15:0], ~a[15:0]};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign mem_rdata_a[g] = memf(mem_addr_a[g]);
    mem_port_arbiter #(.WAIT_CYCLES(g)) u_dut (
      .CLK        (CLK),
      .Reset_L    (Reset_L),
      .if_req     (if_req && (sel == g)),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata_a[g]),
      .if_ready   (if_ready_a[g]),
      .d_rd       (d_rd && (sel == g)),
      .d_wr       (d_wr && (sel == g)),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata_a[g]),
      .d_ready    (d_ready_a[g]),
      .stall_pipe (stall_a[g]),
      .mem_en     (mem_en_a[g]),
      .mem_we     (mem_we_a[g]),
      .mem_addr   (mem_addr_a[g]),
      .mem_wdata  (mem_wdata_a[g]),
      .mem_rdata  (mem_rdata_a[g])
    );
  end

  initial forever #5 CLK = ~CLK;

  typedef struct {
    int          w;
    logic        ireq;
    logic [31:0] iaddr;
    logic        drd;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] e_if;
    logic [31:0] e_d;
    logic        e_ir;
    logic        e_dr;
    int          e_cyc;
    int          e_en;
  } vec_t;

  vec_t vt [8];
  vec_t sb [$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else n_pass++;
  endtask

  // Called at the start of cycle 0. Returns the index of the first cycle with
  // stall_pipe low (-1 on timeout) and the number of stalled cycles with mem_en.
  task automatic wait_step(input int w, output int cyc, output int en);
    cyc = -1;
    en  = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge CLK);
      if (!stall_a[w]) begin
        cyc = c;
        break;
      end
      if (mem_en_a[w]) en++;
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic clear_and_idle();
    @(negedge CLK);
    #1;
    if_req = 1'b0;
    d_rd   = 1'b0;
    d_wr   = 1'b0;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    int   cyc;
    int   en;
    vec_t e;

    //                w  ireq iaddr        drd   dwr   daddr     dwdata
    //                   e_if          e_d           e_ir  e_dr  cyc en
    vt[0] = '{0, 1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,
              32'h2002000A, 32'h0,        1'b1, 1'b0, 2, 1};
    vt[1] = '{1, 1'b1, 32'h44,  1'b1, 1'b0, 32'h10,  32'h0,
              32'h8C030000, 32'h5,        1'b1, 1'b1, 5, 4};
    vt[2] = '{2, 1'b0, 32'h0,   1'b0, 1'b1, 32'h20,  32'hDEADBEEF,
              32'h0,        32'h0,        1'b0, 1'b1, 4, 3};
    vt[3] = '{2, 1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h0,
              32'h0,        32'h0100FEFF, 1'b0, 1'b1, 4, 3};
    vt[4] = '{2, 1'b1, 32'h200, 1'b0, 1'b1, 32'h30,  32'h7,
              32'h0200FDFF, 32'h0100FEFF, 1'b1, 1'b1, 7, 6};
    vt[5] = '{0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h30,  32'h7,
              32'h2002000A, 32'h0,        1'b0, 1'b1, 2, 1};
    vt[6] = '{3, 1'b1, 32'h30,  1'b0, 1'b0, 32'h0,   32'h0,
              32'h0030FFCF, 32'h0,        1'b1, 1'b0, 5, 4};
    vt[7] = '{1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,
              32'h8C030000, 32'h5,        1'b0, 1'b0, 0, 0};

    // Reset held with a fetch requested on the zero-wait instance.
    sel     = 0;
    if_req  = 1'b1;
    if_addr = 32'h44;
    #1 Reset_L = 1'b0;
    #2;
    chk("rst_mem_en",    32'(mem_en_a[0]), 32'h0);
    chk("rst_mem_we",    32'(mem_we_a[0]), 32'h0);
    chk("rst_mem_addr",  mem_addr_a[0],    32'h0);
    chk("rst_mem_wdata", mem_wdata_a[0],   32'h0);
    chk("rst_if_rdata",  if_rdata_a[0],    32'h0);
    chk("rst_d_rdata",   d_rdata_a[0],     32'h0);
    chk("rst_if_ready",  32'(if_ready_a[0]), 32'h0);
    chk("rst_d_ready",   32'(d_ready_a[0]),  32'h0);
    chk("rst_stall",     32'(stall_a[0]),    32'h1);
    #4 Reset_L = 1'b1;
    @(posedge CLK);
    chk("rel_mem_en", 32'(mem_en_a[0]), 32'h1);
    wait_step(0, cyc, en);
    chk("rel_step", 32'(cyc), 32'h0);
    chk("rel_if_rdata", if_rdata_a[0], 32'h8C030000);
    clear_and_idle();

    // Table-driven pipeline steps.
    for (int i = 0; i < 8; i++) begin
      sel     = vt[i].w;
      if_req  = vt[i].ireq;
      if_addr = vt[i].iaddr;
      d_rd    = vt[i].drd;
      d_wr    = vt[i].dwr;
      d_addr  = vt[i].daddr;
      d_wdata = vt[i].dwdata;
      sb.push_back(vt[i]);
      wait_step(vt[i].w, cyc, en);
      e = sb.pop_front();
      chk($sformatf("v%0d_cycles", i),   32'(cyc), 32'(e.e_cyc));
      chk($sformatf("v%0d_busy", i),     32'(en),  32'(e.e_en));
      chk($sformatf("v%0d_if_rdata", i), if_rdata_a[e.w], e.e_if);
      chk($sformatf("v%0d_d_rdata", i),  d_rdata_a[e.w],  e.e_d);
      chk($sformatf("v%0d_if_ready", i), 32'(if_ready_a[e.w]), 32'(e.e_ir));
      chk($sformatf("v%0d_d_ready", i),  32'(d_ready_a[e.w]),  32'(e.e_dr));
      clear_and_idle();
    end

    // Store on the two-wait instance with d_addr changing mid-access.
    sel     = 2;
    d_wr    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) d_addr = 32'h99;
      @(posedge CLK);
      chk($sformatf("st_c%0d_mem_we", c), 32'(mem_we_a[2]), (c >= 1 && c <= 3) ? 32'h1 : 32'h0);
      chk($sformatf("st_c%0d_mem_en", c), 32'(mem_en_a[2]), (c >= 1 && c <= 3) ? 32'h1 : 32'h0);
      if (c >= 1 && c <= 3) begin
        chk($sformatf("st_c%0d_mem_addr", c),  mem_addr_a[2],  32'h20);
        chk($sformatf("st_c%0d_mem_wdata", c), mem_wdata_a[2], 32'hDEADBEEF);
      end
      if (c == 4) begin
        chk("st_d_ready", 32'(d_ready_a[2]), 32'h1);
        chk("st_stall",   32'(stall_a[2]),   32'h0);
      end
      @(negedge CLK);
      #1;
    end
    chk("st_d_rdata_kept", d_rdata_a[2], 32'h0100FEFF);
    if_req = 1'b0;
    d_rd   = 1'b0;
    d_wr   = 1'b0;
    @(negedge CLK);
    #1;

    // Reset pulsed during cycle 2 of a three-wait load.
    sel    = 3;
    d_rd   = 1'b1;
    d_addr = 32'h100;
    @(negedge CLK);
    #1;
    chk("ar_busy_c1", 32'(mem_en_a[3]), 32'h1);
    @(negedge CLK);
    #1;
    Reset_L = 1'b0;
    #1;
    chk("ar_mem_en",  32'(mem_en_a[3]),  32'h0);
    chk("ar_d_ready", 32'(d_ready_a[3]), 32'h0);
    chk("ar_stall",   32'(stall_a[3]),   32'h1);
    @(posedge CLK);
    Reset_L = 1'b1;
    wait_step(3, cyc, en);
    chk("ar_reissue_cycles", 32'(cyc), 32'h4);
    chk("ar_reissue_busy",   32'(en),  32'h4);
    chk("ar_d_rdata",  d_rdata_a[3],     32'h0100FEFF);
    chk("ar_d_ready2", 32'(d_ready_a[3]), 32'h1);
    clear_and_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
